video_timing_ctrl: RTL and testbench



---
 rtl/video_timing_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator that pulls RGB pixels from a
// valid/ready stream, locks the stream to the raster using the start-of-frame
// marker, blanks and flags underflow, and re-locks after frame errors while
// the sync timing keeps running undisturbed.
module video_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic        pixclk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_data,
  input  logic        pix_sof,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        vde,
  output logic        hSync,
  output logic        vSync,
  output logic        frame_start,
  output logic        underflow,
  output logic        frame_err,
  input  logic        err_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra bit of headroom so the sync window end never overflows.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;

  logic [23:0]     rgb_q, rgb_d;
  logic            vde_q, hsync_q, vsync_q, fs_q;
  logic            uf_q, fe_q;
  logic            set_uf, set_fe;

  logic            at_origin, in_active, in_hsync, in_vsync;

  // Raster position decode; vsync only changes at h=0 because v does.
  always_comb begin
    at_origin = (h_q == '0) && (v_q == '0);
    in_active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    in_hsync  = (h_q >= HS_START) && (h_q < HS_END);
    in_vsync  = (v_q >= VS_START) && (v_q < VS_END);
  end

  // Next raster position: held at origin while disabled, free-running otherwise.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Raster counter register.
  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // FSM state register.
  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: lock on a sof beat at the origin, drop back on any sof mismatch.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_ALIGN;
        S_ALIGN: if (at_origin && pix_valid && pix_sof) state_d = S_RUN;
        S_RUN:   if (in_active && pix_valid && (pix_sof != at_origin)) state_d = S_ALIGN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: stream handshake, pixel selection and sticky error sets.
  always_comb begin
    pix_ready = 1'b0;
    rgb_d     = '0;
    set_uf    = 1'b0;
    set_fe    = 1'b0;
    if (resetn && enable) begin
      unique case (state_q)
        S_ALIGN: begin
          if (at_origin) begin
            pix_ready = pix_valid;
            if (pix_valid && pix_sof) rgb_d = pix_data;
          end else begin
            // Non-sof beats are drained; a sof beat waits for the origin.
            pix_ready = pix_valid && !pix_sof;
          end
        end
        S_RUN: begin
          if (in_active) begin
            pix_ready = 1'b1;
            if (!pix_valid) begin
              set_uf = 1'b1;
            end else if (pix_sof != at_origin) begin
              set_fe = 1'b1;
            end else begin
              rgb_d = pix_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered video outputs, all aligned one cycle behind the raster position.
  always_ff @(posedge pixclk) begin
    if (!resetn || !enable) begin
      rgb_q   <= '0;
      vde_q   <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      vde_q   <= in_active;
      hsync_q <= in_hsync ? H_POL : ~H_POL;
      vsync_q <= in_vsync ? V_POL : ~V_POL;
      fs_q    <= at_origin;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      uf_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      uf_q <= set_uf | (uf_q & ~err_clr);
      fe_q <= set_fe | (fe_q & ~err_clr);
    end
  end

  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign vde         = vde_q;
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: directed scenarios followed by randomized traffic,
// checked every cycle against a frame-position reference model.
module tb_video_timing_ctrl;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BEATS = HA * VA;

  logic        pixclk = 1'b0;
  logic        resetn, enable, pix_valid, pix_ready, pix_sof, err_clr;
  logic [23:0] pix_data;
  logic [7:0]  red, green, blue;
  logic        vde, hSync, vSync, frame_start, underflow, frame_err;

  always #5 pixclk = ~pixclk;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .pixclk(pixclk), .resetn(resetn), .enable(enable),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .red(red), .green(green), .blue(blue),
    .vde(vde), .hSync(hSync), .vSync(vSync), .frame_start(frame_start),
    .underflow(underflow), .frame_err(frame_err), .err_clr(err_clr)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: mode 0 = idle, 1 = hunting for sof, 2 = locked.
  int          m_mode = 0;
  int          m_pos = 0;
  bit          m_uf = 0, m_fe = 0;
  logic [23:0] e_rgb = '0;
  bit          e_vde = 0, e_hs = 1, e_vs = 1, e_fs = 0, e_ready = 0;
  bit          have_exp = 0;

  // Stream source: beat n carries data n, sof on the first beat of each frame.
  int src_n = 1;
  bit dir_phase = 0;
  bit seen_px = 0;
  int last_fs = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s cycle %0d: bound expired, got timeout expected event", name, cyc);
  endtask

  task automatic model_eval();
    int h, v, nm;
    bit act, org, su, se;
    logic [23:0] rgb;
    h   = m_pos % HT;
    v   = m_pos / HT;
    act = (h < HA) && (v < VA);
    org = (m_pos == 0);
    su  = 0;
    se  = 0;
    rgb = '0;
    nm  = m_mode;
    e_ready = 0;
    if (resetn && enable) begin
      if (m_mode == 1) e_ready = org ? pix_valid : (pix_valid && !pix_sof);
      else if (m_mode == 2) e_ready = act;
    end
    if (!resetn) begin
      m_mode = 0; m_pos = 0; m_uf = 0; m_fe = 0;
      e_rgb = '0; e_vde = 0; e_hs = 1; e_vs = 1; e_fs = 0;
    end else if (!enable) begin
      m_mode = 0; m_pos = 0;
      e_rgb = '0; e_vde = 0; e_hs = 1; e_vs = 1; e_fs = 0;
      if (err_clr) begin m_uf = 0; m_fe = 0; end
    end else begin
      if (m_mode == 0) begin
        nm = 1;
      end else if (m_mode == 1) begin
        if (org && pix_valid && pix_sof) begin rgb = pix_data; nm = 2; end
      end else if (act) begin
        if (!pix_valid) su = 1;
        else if (pix_sof != org) begin se = 1; nm = 1; end
        else rgb = pix_data;
      end
      e_rgb = rgb;
      e_vde = act;
      e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      e_fs  = org;
      m_uf  = su | (m_uf & !err_clr);
      m_fe  = se | (m_fe & !err_clr);
      m_mode = nm;
      m_pos  = (m_pos + 1) % FT;
    end
  endtask

  // One clock: drive at negedge, check ready, clock, then check registered outputs.
  task automatic cycle(input bit rn, input bit en, input bit vld, input bit clr, input bit flip);
    resetn    = rn;
    enable    = en;
    pix_valid = vld;
    err_clr   = clr;
    pix_data  = src_n[23:0];
    pix_sof   = (((src_n - 1) % BEATS) == 0) ^ flip;
    #1;
    model_eval();
    chk("pix_ready", {31'b0, pix_ready}, {31'b0, e_ready});
    if (e_ready && vld) src_n++;
    @(posedge pixclk);
    #2;
    cyc++;
    have_exp = 1;
    chk("rgb", {8'b0, red, green, blue}, {8'b0, e_rgb});
    chk("vde", {31'b0, vde}, {31'b0, e_vde});
    chk("hsync", {31'b0, hSync}, {31'b0, e_hs});
    chk("vsync", {31'b0, vSync}, {31'b0, e_vs});
    chk("frame_start", {31'b0, frame_start}, {31'b0, e_fs});
    chk("underflow", {31'b0, underflow}, {31'b0, m_uf});
    chk("frame_err", {31'b0, frame_err}, {31'b0, m_fe});
    if (dir_phase && frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", cyc - last_fs, FT);
      last_fs = cyc;
    end
    if (dir_phase && !seen_px && {red, green, blue} != 24'h0) begin
      seen_px = 1;
      chk("first_px", {8'b0, red, green, blue}, 32'h000001);
      chk("first_px_fs", {31'b0, frame_start}, 32'd1);
    end
    @(negedge pixclk);
  endtask

  initial begin
    bit found;
    resetn = 0; enable = 0; pix_valid = 0; err_clr = 0; pix_data = '0; pix_sof = 0;
    @(negedge pixclk);

    // Reset, then idle with enable low.
    repeat (2) cycle(0, 0, 0, 0, 0);
    repeat (6) cycle(1, 0, 0, 0, 0);
    chk("idle_vde", {31'b0, vde}, 32'd0);
    chk("idle_hs", {31'b0, hSync}, 32'd1);
    chk("idle_vs", {31'b0, vSync}, 32'd1);
    chk("idle_rgb", {8'b0, red, green, blue}, 32'd0);
    chk("idle_ready", {31'b0, pix_ready}, 32'd0);

    // Stream offered mid-frame; lock happens at the next origin.
    dir_phase = 1;
    src_n = 1;
    repeat (20) cycle(1, 1, 0, 0, 0);
    repeat (FT * 3) cycle(1, 1, 1, 0, 0);
    chk("lock_fe", {31'b0, frame_err}, 32'd0);
    chk("lock_uf", {31'b0, underflow}, 32'd0);
    if (!seen_px) bound_fail("first_px_seen");
    dir_phase = 0;

    // Underflow at (h=2, v=1) while locked, then clear.
    found = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      if (m_mode == 2 && m_pos == HT + 2) begin found = 1; break; end
      cycle(1, 1, 1, 0, 0);
    end
    if (!found) bound_fail("reach_uf_pos");
    cycle(1, 1, 0, 0, 0);
    chk("uf_rgb", {8'b0, red, green, blue}, 32'd0);
    chk("uf_set", {31'b0, underflow}, 32'd1);
    cycle(1, 1, 1, 1, 0);
    chk("uf_clr", {31'b0, underflow}, 32'd0);

    // Misplaced sof at (h=1, v=0) while locked.
    found = 0;
    for (int i = 0; i < 6 * FT; i++) begin
      if (m_mode == 2 && m_pos == 1) begin found = 1; break; end
      cycle(1, 1, 1, 0, 0);
    end
    if (!found) bound_fail("reach_fe_pos");
    cycle(1, 1, 1, 0, 1);
    chk("fe_rgb", {8'b0, red, green, blue}, 32'd0);
    chk("fe_set", {31'b0, frame_err}, 32'd1);
    repeat (2 * FT) cycle(1, 1, 1, 0, 0);

    // Enable drop at (h=2, v=1), then re-enable.
    found = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      if (m_mode != 0 && m_pos == HT + 2) begin found = 1; break; end
      cycle(1, 1, 1, 0, 0);
    end
    if (!found) bound_fail("reach_en_pos");
    cycle(1, 0, 1, 0, 0);
    chk("en_vde", {31'b0, vde}, 32'd0);
    chk("en_hs", {31'b0, hSync}, 32'd1);
    chk("en_vs", {31'b0, vSync}, 32'd1);
    cycle(1, 1, 1, 0, 0);
    chk("reen_fs", {31'b0, frame_start}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 999) != 0,
            $urandom_range(0, 299) != 0,
            $urandom_range(0, 19) != 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
